// File: rtl/spi_oled_seq_pkg.sv
// Shared definitions for the SPI OLED command sequencer: queue entry layout,
// peripheral and host register offsets, and the sequencer state encoding.
package spi_oled_seq_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_RST   = 2'd2,
    OP_DELAY = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } entry_t;

  localparam logic [31:0] PER_CS   = 32'h04;
  localparam logic [31:0] PER_DATA = 32'h08;
  localparam logic [31:0] PER_DC   = 32'h10;
  localparam logic [31:0] PER_RST  = 32'h14;

  localparam logic [31:0] HOST_PUSH    = 32'h00;
  localparam logic [31:0] HOST_STATUS  = 32'h04;
  localparam logic [31:0] HOST_CTRL    = 32'h08;
  localparam logic [31:0] HOST_PASS_LO = 32'h40;
  localparam logic [31:0] HOST_PASS_HI = 32'h5C;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PASS, ST_CS_LO, ST_FETCH, ST_DC, ST_XFER, ST_RSTW, ST_DELAY, ST_CS_HI
  } state_e;

endpackage

// File: rtl/spi_oled_seq_fifo.sv
// Synchronous FIFO with occupancy level and a single-cycle flush.
module spi_oled_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers alone define which words are valid,
  // and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_oled_seq.sv
// Replays queued OLED operations as peripheral register writes with CS/DC
// framing, and passes direct host accesses through while idle.
module spi_oled_seq
  import spi_oled_seq_pkg::*;
#(
  parameter int FIFO_DEPTH        = 16,
  parameter int DELAY_UNIT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  host_wr,
  input  logic        host_rd,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdat,
  output logic [31:0] host_rdat,
  output logic        host_done,
  output logic [3:0]  per_wr,
  output logic        per_rd,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdat,
  input  logic [31:0] per_rdat,
  input  logic        per_done,
  output logic        busy,
  output logic        irq
);

  localparam int          LW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] UNIT = 32'(DELAY_UNIT_CYCLES);

  state_e        state, state_n;
  logic          host_wr_any, host_req, pass_addr, own_req, pass_req, pass_done;
  logic          push, push_acc, pop, flush_now, flushed, flush_eff, fifo_more;
  logic [9:0]    fifo_rdata;
  entry_t        head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty;
  logic          cs_sh, dc_sh, overflow, irq_en;
  logic [31:0]   dly_cnt, dly_n, rd_mux;
  logic [3:0]    wr_n;
  logic          rd_n, outstanding, fin, issue;
  logic [31:0]   addr_n, wdat_n, issue_addr, issue_wdat;

  assign host_wr_any = |host_wr;
  assign host_req    = (host_wr_any | host_rd) & ~host_done;
  assign pass_addr   = (host_addr >= HOST_PASS_LO) && (host_addr <= HOST_PASS_HI);
  assign own_req     = host_req & ~pass_addr;
  assign pass_req    = host_req & pass_addr;
  assign push        = own_req & host_wr_any & (host_addr == HOST_PUSH);
  assign push_acc    = push & ~fifo_full;
  assign flush_now   = own_req & host_wr_any & (host_addr == HOST_CTRL) & host_wdat[1];
  assign flush_eff   = flushed | flush_now;
  assign fifo_more   = (fifo_level > LW'(1)) | push_acc;
  assign outstanding = (|per_wr) | per_rd;
  assign fin         = outstanding & per_done;
  assign pass_done   = (state == ST_PASS) & fin;
  assign head        = entry_t'(fifo_rdata);
  assign busy        = state != ST_IDLE;
  assign irq         = irq_en & fifo_empty & ~busy;

  spi_oled_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (host_wdat[9:0]),
    .pop    (pop),
    .flush  (flush_now),
    .rdata  (fifo_rdata),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    wr_n       = per_wr;
    rd_n       = per_rd;
    addr_n     = per_addr;
    wdat_n     = per_wdat;
    dly_n      = dly_cnt;
    pop        = 1'b0;
    issue      = 1'b0;
    issue_addr = '0;
    issue_wdat = '0;
    if (fin) begin
      wr_n = 4'h0;
      rd_n = 1'b0;
    end
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !flush_now) state_n = cs_sh ? ST_CS_LO : ST_FETCH;
        else if (pass_req)             state_n = ST_PASS;
      end
      ST_PASS: begin
        if (!outstanding) begin
          wr_n   = host_wr_any ? 4'hF : 4'h0;
          rd_n   = host_rd & ~host_wr_any;
          addr_n = host_addr - HOST_PASS_LO;
          wdat_n = host_wdat;
        end else if (per_done) begin
          state_n = ST_IDLE;
        end
      end
      ST_CS_LO: begin
        if (!outstanding) begin
          issue      = 1'b1;
          issue_addr = PER_CS;
        end else if (per_done) begin
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (flush_eff || fifo_empty) begin
          state_n = ST_CS_HI;
        end else begin
          case (head.op)
            OP_CMD, OP_DATA: state_n = ((head.op == OP_DATA) != dc_sh) ? ST_DC : ST_XFER;
            OP_RST:          state_n = ST_RSTW;
            default: begin
              if (head.arg == 8'd0) begin
                pop     = 1'b1;
                state_n = fifo_more ? ST_FETCH : ST_CS_HI;
              end else begin
                dly_n   = {24'd0, head.arg} * UNIT - 32'd1;
                state_n = ST_DELAY;
              end
            end
          endcase
        end
      end
      ST_DC: begin
        if (!outstanding) begin
          if (flush_eff) begin
            state_n = ST_CS_HI;
          end else begin
            issue      = 1'b1;
            issue_addr = PER_DC;
            issue_wdat = {31'd0, head.op == OP_DATA};
          end
        end else if (per_done) begin
          state_n = flush_eff ? ST_CS_HI : ST_XFER;
        end
      end
      ST_XFER, ST_RSTW: begin
        if (!outstanding) begin
          if (flush_eff) begin
            state_n = ST_CS_HI;
          end else begin
            issue      = 1'b1;
            issue_addr = (state == ST_XFER) ? PER_DATA : PER_RST;
            issue_wdat = (state == ST_XFER) ? {24'd0, head.arg} : {31'd0, head.arg[0]};
          end
        end else if (per_done) begin
          // A flushed op is finished but not popped: the queue already holds
          // only entries pushed after the flush.
          pop     = ~flush_eff;
          state_n = (!flush_eff && fifo_more) ? ST_FETCH : ST_CS_HI;
        end
      end
      ST_DELAY: begin
        if (flush_eff) begin
          state_n = ST_CS_HI;
        end else if (dly_cnt == 32'd0) begin
          pop     = 1'b1;
          state_n = fifo_more ? ST_FETCH : ST_CS_HI;
        end else begin
          dly_n = dly_cnt - 32'd1;
        end
      end
      ST_CS_HI: begin
        if (!outstanding) begin
          if (cs_sh) begin
            state_n = ST_IDLE;
          end else begin
            issue      = 1'b1;
            issue_addr = PER_CS;
            issue_wdat = 32'd1;
          end
        end else if (per_done) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (issue) begin
      wr_n   = 4'hF;
      addr_n = issue_addr;
      wdat_n = issue_wdat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      per_wr   <= 4'h0;
      per_rd   <= 1'b0;
      per_addr <= '0;
      per_wdat <= '0;
      dly_cnt  <= '0;
      flushed  <= 1'b0;
      cs_sh    <= 1'b1;
      dc_sh    <= 1'b0;
    end else begin
      state    <= state_n;
      per_wr   <= wr_n;
      per_rd   <= rd_n;
      per_addr <= addr_n;
      per_wdat <= wdat_n;
      dly_cnt  <= dly_n;
      flushed  <= (state == ST_IDLE) ? 1'b0 : (flushed | flush_now);
      // Shadows track any completed write, including passthrough ones.
      if (fin && (|per_wr)) begin
        if (per_addr == PER_CS) cs_sh <= per_wdat[0];
        if (per_addr == PER_DC) dc_sh <= per_wdat[0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (host_rd && !host_wr_any) begin
      case (host_addr)
        HOST_STATUS: rd_mux = {20'd0, 8'(fifo_level), overflow, fifo_full, fifo_empty, busy};
        HOST_CTRL:   rd_mux = {31'd0, irq_en};
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      host_done <= 1'b0;
      host_rdat <= '0;
      overflow  <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      host_done <= own_req | pass_done;
      host_rdat <= own_req ? rd_mux : (pass_done ? per_rdat : '0);
      if (push && fifo_full)
        overflow <= 1'b1;
      else if (own_req && host_wr_any && host_addr == HOST_STATUS && host_wdat[3])
        overflow <= 1'b0;
      if (own_req && host_wr_any && host_addr == HOST_CTRL) irq_en <= host_wdat[0];
    end
  end

endmodule

// File: tb/tb_spi_oled_seq.sv
// Directed bench for spi_oled_seq: register table, framing sequences, delay,
// overflow, stalled passthrough and flush, against a simple peripheral model.
module tb_spi_oled_seq;
  import spi_oled_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int UNIT  = 4;

  logic        clk, resetn;
  logic [3:0]  host_wr;
  logic        host_rd;
  logic [31:0] host_addr, host_wdat, host_rdat;
  logic        host_done;
  logic [3:0]  per_wr;
  logic        per_rd;
  logic [31:0] per_addr, per_wdat, per_rdat;
  logic        per_done;
  logic        busy, irq;

  spi_oled_seq #(.FIFO_DEPTH(DEPTH), .DELAY_UNIT_CYCLES(UNIT)) dut (
    .clk(clk), .resetn(resetn),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wdat(host_wdat),
    .host_rdat(host_rdat), .host_done(host_done),
    .per_wr(per_wr), .per_rd(per_rd), .per_addr(per_addr), .per_wdat(per_wdat),
    .per_rdat(per_rdat), .per_done(per_done),
    .busy(busy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int lat = 0, wait_cnt = 0, viol = 0, delay_cycles = 0, done_cnt = 0;
  bit stall = 0, mon_req, prev_req = 0, prev_done = 0;
  logic [31:0] prev_addr, prev_wdat;
  logic [3:0]  prev_wr;
  logic [63:0] log_q[$];
  logic [63:0] exp_q[$];

  // Peripheral model plus handshake monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    mon_req = (|per_wr) || per_rd;
    if (resetn) begin
      if (per_wr != 4'h0 && per_wr != 4'hF) viol++;
      if (mon_req && prev_done) viol++;
      if (mon_req && prev_req && !prev_done &&
          (per_addr !== prev_addr || per_wdat !== prev_wdat || per_wr !== prev_wr)) viol++;
      if (dut.state == ST_DELAY) delay_cycles++;
      if (host_done) done_cnt++;
    end
    if (per_done) begin
      per_done = 1'b0;
    end else if (mon_req && !stall) begin
      if (wait_cnt >= lat) begin
        per_done = 1'b1;
        per_rdat = 32'hC0DE0000 | per_addr;
        if (|per_wr) log_q.push_back({per_addr, per_wdat});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    prev_req  = mon_req;
    prev_done = per_done;
    prev_addr = per_addr;
    prev_wdat = per_wdat;
    prev_wr   = per_wr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_access(input string name, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdat, input int max_cyc,
                             output logic [31:0] rdat, output int cyc);
    bit got = 0;
    @(negedge clk);
    if (host_done) @(negedge clk);
    host_wr   = wr ? 4'hF : 4'h0;
    host_rd   = !wr;
    host_addr = addr;
    host_wdat = wdat;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      got = host_done;
    end
    rdat    = host_rdat;
    host_wr = 4'h0;
    host_rd = 1'b0;
    check({name, " done"}, 64'(got), 64'd1);
  endtask

  task automatic push(input string name, input logic [9:0] entry);
    logic [31:0] r;
    int c;
    host_access(name, 1'b1, HOST_PUSH, {22'd0, entry}, 10, r, c);
    check({name, " latency"}, 64'(c), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(posedge clk);
    while (busy && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, " idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_log(input string name);
    check({name, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s w%0d", name, i), log_q[i], exp_q[i]);
    log_q.delete();
  endtask

  function automatic logic [63:0] w(input logic [31:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_rdat;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r;
    int c, n;
    host_wr = 4'h0; host_rd = 1'b0; host_addr = '0; host_wdat = '0;
    per_done = 1'b0; per_rdat = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst per_wr", 64'(per_wr), 64'd0);
    check("rst per_rd", 64'(per_rd), 64'd0);
    check("rst per_addr", 64'(per_addr), 64'd0);
    check("rst per_wdat", 64'(per_wdat), 64'd0);
    check("rst host_done", 64'(host_done), 64'd0);
    check("rst host_rdat", 64'(host_rdat), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst irq", 64'(irq), 64'd0);
    @(negedge clk) resetn = 1'b1;

    // Own-register table: {wr, addr, wdat, expected read data, expected irq}
    vecs[0] = '{1'b0, 32'h04,  32'h0,    32'h002, 1'b0};
    vecs[1] = '{1'b0, 32'h08,  32'h0,    32'h000, 1'b0};
    vecs[2] = '{1'b0, 32'h100, 32'h0,    32'h000, 1'b0};
    vecs[3] = '{1'b1, 32'h100, 32'hFFFF, 32'h000, 1'b0};
    vecs[4] = '{1'b1, 32'h08,  32'h1,    32'h000, 1'b1};
    vecs[5] = '{1'b0, 32'h08,  32'h0,    32'h001, 1'b1};
    vecs[6] = '{1'b1, 32'h08,  32'h3,    32'h000, 1'b1};
    vecs[7] = '{1'b0, 32'h08,  32'h0,    32'h001, 1'b1};
    vecs[8] = '{1'b0, 32'h04,  32'h0,    32'h002, 1'b1};
    vecs[9] = '{1'b1, 32'h04,  32'h8,    32'h000, 1'b1};
    for (int i = 0; i < 10; i++) begin
      host_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdat, 10, r, c);
      check($sformatf("vec%0d latency", i), 64'(c), 64'd1);
      if (!vecs[i].wr) check($sformatf("vec%0d rdat", i), 64'(r), 64'(vecs[i].exp_rdat));
      check($sformatf("vec%0d irq", i), 64'(irq), 64'(vecs[i].exp_irq));
    end

    // CMD then DATA in one frame, with a DC switch before the data byte.
    push("t1 p0", 10'h0AE);
    push("t1 p1", 10'h155);
    check("t1 irq busy", 64'(irq), 64'd0);
    wait_idle("t1");
    exp_q = '{w(32'h04, 0), w(32'h08, 32'hAE), w(32'h10, 1), w(32'h08, 32'h55), w(32'h04, 1)};
    check_log("t1");
    check("t1 irq end", 64'(irq), 64'd1);

    // Two CMDs: one DC write back to 0, single CS frame.
    push("t2 p0", 10'h001);
    push("t2 p1", 10'h002);
    wait_idle("t2");
    exp_q = '{w(32'h04, 0), w(32'h10, 0), w(32'h08, 32'h01), w(32'h08, 32'h02), w(32'h04, 1)};
    check_log("t2");

    // RST 0, DELAY 3, RST 1: 3 * 4 cycles spent in DELAY.
    delay_cycles = 0;
    push("t3 p0", 10'h200);
    push("t3 p1", 10'h303);
    push("t3 p2", 10'h201);
    wait_idle("t3");
    exp_q = '{w(32'h04, 0), w(32'h14, 0), w(32'h14, 1), w(32'h04, 1)};
    check_log("t3");
    check("t3 delay cycles", 64'(delay_cycles), 64'd12);

    // Overflow while the peripheral stalls.
    stall = 1;
    for (int i = 0; i <= DEPTH; i++) push($sformatf("t4 p%0d", i), 10'(8'h10 + i));
    host_access("t4 status", 1'b0, HOST_STATUS, 0, 10, r, c);
    check("t4 status full", 64'(r), 64'h04D);
    host_access("t4 clear", 1'b1, HOST_STATUS, 32'h8, 10, r, c);
    host_access("t4 status clr", 1'b0, HOST_STATUS, 0, 10, r, c);
    check("t4 status cleared", 64'(r), 64'h045);
    stall = 0;
    wait_idle("t4");
    exp_q = '{w(32'h04, 0), w(32'h08, 32'h10), w(32'h08, 32'h11), w(32'h08, 32'h12),
              w(32'h08, 32'h13), w(32'h04, 1)};
    check_log("t4");

    // Passthrough write while the sequencer is busy: stalled until IDLE.
    stall = 1;
    push("t5 p0", 10'h021);
    repeat (2) @(posedge clk);
    done_cnt = 0;
    fork
      host_access("t5 pass", 1'b1, 32'h48, 32'h77, 300, r, c);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("t5 stalled done", 64'(done_cnt), 64'd0);
        check("t5 stalled busy", 64'(busy), 64'd1);
        stall = 0;
      end
    join
    repeat (3) @(posedge clk);
    check("t5 waited", 64'(c > 20), 64'd1);
    check("t5 done pulses", 64'(done_cnt), 64'd1);
    wait_idle("t5");
    exp_q = '{w(32'h04, 0), w(32'h08, 32'h21), w(32'h04, 1), w(32'h08, 32'h77)};
    check_log("t5");
    host_access("t5 pass rd", 1'b0, 32'h5C, 0, 100, r, c);
    check("t5 pass rdat", 64'(r), 64'hC0DE001C);

    // Flush while the first data byte is in flight.
    lat = 10;
    push("t6 p0", 10'h031);
    push("t6 p1", 10'h032);
    push("t6 p2", 10'h033);
    n = 0;
    while (!((|per_wr) && per_addr == PER_DATA) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6 xfer seen", 64'((|per_wr) && per_addr == PER_DATA), 64'd1);
    host_access("t6 flush", 1'b1, HOST_CTRL, 32'h3, 10, r, c);
    host_access("t6 status", 1'b0, HOST_STATUS, 0, 10, r, c);
    check("t6 status flushed", 64'(r), 64'h003);
    wait_idle("t6");
    lat = 0;
    exp_q = '{w(32'h04, 0), w(32'h08, 32'h31), w(32'h04, 1)};
    check_log("t6");
    check("t6 irq", 64'(irq), 64'd1);

    check("handshake violations", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
